stall_countdown_ctrl: RTL and testbench
=======================================

Name: stall_countdown_ctrl

Overview:
Countdown/stall sequencer for the dual-issue 5-stage MIPS pipeline. It consumes the stall detector's countdown request (CDen/CDAmt) and per-pipe stage enables. It produces the registered stall_1/stall_2 signals fed back to the detector, plus EX-stage bubble-insert strobes. The block sits between the stall detector and the IF/ID/EX pipeline registers of both pipes.

Parameters:
CD_W, 3, width of countdown amount and internal counter
STAT_W, 32, width of statistics counters (used only with STALL_STATS_EN)

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
cd_en  in  1  countdown load request from stall detector
cd_amt  in  CD_W  number of stall cycles requested
cd_src  in  1  requesting pipe: 0 = pipe 1, 1 = pipe 2
halt  in  1  pipeline halt (syscall); freezes countdown
iden_1, exen_1  in  1 each  pipe 1 ID/EX enables from detector
iden_2, exen_2  in  1 each  pipe 2 ID/EX enables from detector
stall_1  out  1  pipe 1 countdown stall active
stall_2  out  1  pipe 2 countdown stall active
bubble_ex_1  out  1  insert NOP into pipe 1 EX register this cycle
bubble_ex_2  out  1  insert NOP into pipe 2 EX register this cycle
cd_busy  out  1  countdown in progress
cd_remaining  out  CD_W  cycles of stall left, including the current cycle
stall_cycles  out  STAT_W  total stall cycles (optional feature)
bubble_count  out  STAT_W  total bubbles inserted (optional feature)

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, counter=0, src=0. All outputs are 0, including the stat counters.
- FSM states: IDLE, COUNT, HOLD.
- IDLE:
  - cd_en=1 and cd_amt!=0: load counter=cd_amt, latch src=cd_src, go to COUNT.
  - cd_en=1 with cd_amt=0: ignored, stay IDLE.
- COUNT: each cycle with halt=0, counter decrements. When counter==1 at a posedge, counter becomes 0 and the FSM returns to IDLE.
- HOLD: entered from COUNT when halt=1. The counter is frozen. The FSM returns to COUNT on the first cycle with halt=0, and decrementing resumes that cycle.
- halt=1 in IDLE with cd_en: the request is still loaded. The FSM enters HOLD directly.
- Stall outputs:
  - stall_1 = cd_busy && src==0; stall_2 = cd_busy && src==1. These are registered, never both high.
  - cd_busy=1 in COUNT and HOLD; cd_remaining=counter.
  - Latency: request sampled at edge N, stall high from cycle N+1 for exactly cd_amt cycles (with halt low), low at cycle N+1+cd_amt.
- cd_en while cd_busy=1: ignored. No reload, no extension, src unchanged.
- Back-to-back: a new cd_en in the cycle where counter==1 is ignored (still busy). The earliest accepted reload is the first IDLE cycle.
- Bubble insert:
  - bubble_ex_k is registered: set at edge N if iden_k=0 and exen_k=1 were sampled in cycle N, else cleared.
  - Width: one cycle per qualifying sample. Sustained holds give continuous bubbles.
  - bubble_ex_k is forced 0 while stall_k=1, because the EX stage is frozen by the detector.
  - Both pipes are evaluated independently; simultaneous bubbles are allowed.
- Counter arithmetic: unsigned CD_W bits, no wrap. Decrement never occurs at 0.

Optional Feature:
STALL_STATS_EN.
- Defined: stall_cycles increments each cycle cd_busy=1. bubble_count adds bubble_ex_1 + bubble_ex_2 (0..2) each cycle. Both counters saturate at all-ones and clear on rst.
- Undefined: no counter logic is built; the stall_cycles and bubble_count ports stay present and are tied to 0.

Test Plan:
- Basic pipe-1 stall: cd_en=1, cd_amt=2, cd_src=0 for one cycle at edge 5 -> stall_1=1 in cycles 6-7, cd_remaining 2 then 1, stall_1=0 and cd_busy=0 in cycle 8; stall_2=0 throughout.
- Zero amount: cd_en=1, cd_amt=0 -> cd_busy stays 0, no stall.
- Halt mid-count: cd_amt=3, cd_src=1; halt=1 for 4 cycles after the first stall cycle -> stall_2 stays high 3+4=7 cycles total, cd_remaining held at 2 during halt.
- Ignored reload: during an active cd_amt=3 count, pulse cd_en with cd_amt=7, cd_src=0 -> stall_2 duration unchanged at 3, stall_1 never asserted.
- Bubble: iden_1=0, exen_1=1 for 2 cycles with no countdown -> bubble_ex_1 high 2 cycles, one cycle later. Same pattern during stall_1=1 -> bubble_ex_1 stays 0.
- Reset mid-count: rst=1 while cd_remaining=2 -> next cycle all outputs 0, state IDLE. With STALL_STATS_EN, cd_amt=4 then 2 simultaneous bubble cycles -> stall_cycles=4, bubble_count=4.

Source files
------------

// File: rtl/stall_countdown_ctrl.sv
// Countdown stall sequencer and EX bubble strobes for the dual-issue pipeline.
// Optional statistics counters are built only when STALL_STATS_EN is defined.
module stall_countdown_ctrl #(
  parameter int CD_W   = 3,
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cd_en,
  input  logic [CD_W-1:0]   cd_amt,
  input  logic              cd_src,
  input  logic              halt,
  input  logic              iden_1,
  input  logic              exen_1,
  input  logic              iden_2,
  input  logic              exen_2,
  output logic              stall_1,
  output logic              stall_2,
  output logic              bubble_ex_1,
  output logic              bubble_ex_2,
  output logic              cd_busy,
  output logic [CD_W-1:0]   cd_remaining,
  output logic [STAT_W-1:0] stall_cycles,
  output logic [STAT_W-1:0] bubble_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CD_W-1:0] cnt;
  logic [CD_W-1:0] cnt_nxt;
  logic            src;
  logic            src_nxt;
  logic            bub_1_q;
  logic            bub_2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      src     <= 1'b0;
      bub_1_q <= 1'b0;
      bub_2_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      src     <= src_nxt;
      bub_1_q <= ~iden_1 & exen_1;
      bub_2_q <= ~iden_2 & exen_2;
    end
  end

  // Requests arriving while busy are dropped, including on the last count.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    src_nxt   = src;
    unique case (1'b1)
      (state == IDLE): begin
        if (cd_en && (cd_amt != '0)) begin
          cnt_nxt   = cd_amt;
          src_nxt   = cd_src;
          state_nxt = halt ? HOLD : COUNT;
        end
      end
      (state == COUNT),
      (state == HOLD): begin
        if (halt) begin
          state_nxt = HOLD;
        end else begin
          if (cnt != '0) begin
            cnt_nxt = cnt - CD_W'(1);
          end
          state_nxt = (cnt <= CD_W'(1)) ? IDLE : COUNT;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        src_nxt   = 1'b0;
      end
    endcase
  end

  // EX of a stalled pipe is frozen, so its bubble strobe is masked.
  always_comb begin
    cd_busy      = (state != IDLE);
    cd_remaining = cnt;
    stall_1      = cd_busy & ~src;
    stall_2      = cd_busy & src;
    bubble_ex_1  = bub_1_q & ~stall_1;
    bubble_ex_2  = bub_2_q & ~stall_2;
  end

`ifdef STALL_STATS_EN
  logic [STAT_W-1:0] stall_q;
  logic [STAT_W-1:0] bub_q;
  logic [STAT_W:0]   bub_sum;
  logic [1:0]        bub_inc;

  always_comb begin
    bub_inc = {1'b0, bubble_ex_1} + {1'b0, bubble_ex_2};
    bub_sum = {1'b0, bub_q} + {{(STAT_W-1){1'b0}}, bub_inc};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      bub_q   <= '0;
    end else begin
      if (cd_busy && (stall_q != '1)) begin
        stall_q <= stall_q + STAT_W'(1);
      end
      bub_q <= bub_sum[STAT_W] ? '1 : bub_sum[STAT_W-1:0];
    end
  end

  assign stall_cycles = stall_q;
  assign bubble_count = bub_q;
`else
  assign stall_cycles = '0;
  assign bubble_count = '0;
`endif

endmodule

// File: tb/tb_stall_countdown_ctrl.sv
// Directed vector bench for stall_countdown_ctrl.
// Table rows plus hand sequences for halt, reset and statistics.
module tb_stall_countdown_ctrl;

  localparam int CD_W   = 3;
  localparam int STAT_W = 32;

  logic              clk;
  logic              rst;
  logic              cd_en;
  logic [CD_W-1:0]   cd_amt;
  logic              cd_src;
  logic              halt;
  logic              iden_1;
  logic              exen_1;
  logic              iden_2;
  logic              exen_2;
  logic              stall_1;
  logic              stall_2;
  logic              bubble_ex_1;
  logic              bubble_ex_2;
  logic              cd_busy;
  logic [CD_W-1:0]   cd_remaining;
  logic [STAT_W-1:0] stall_cycles;
  logic [STAT_W-1:0] bubble_count;

  int total;
  int bad;

  stall_countdown_ctrl #(.CD_W(CD_W), .STAT_W(STAT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .cd_en        (cd_en),
    .cd_amt       (cd_amt),
    .cd_src       (cd_src),
    .halt         (halt),
    .iden_1       (iden_1),
    .exen_1       (exen_1),
    .iden_2       (iden_2),
    .exen_2       (exen_2),
    .stall_1      (stall_1),
    .stall_2      (stall_2),
    .bubble_ex_1  (bubble_ex_1),
    .bubble_ex_2  (bubble_ex_2),
    .cd_busy      (cd_busy),
    .cd_remaining (cd_remaining),
    .stall_cycles (stall_cycles),
    .bubble_count (bubble_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [2:0] amt;
    logic       src;
    logic       hlt;
    logic       id1;
    logic       ex1;
    logic       id2;
    logic       ex2;
    logic       s1;
    logic       s2;
    logic       b1;
    logic       b2;
    logic       busy;
    logic [2:0] rem;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    rst    = 1'b0;
    cd_en  = 1'b0;
    cd_amt = '0;
    cd_src = 1'b0;
    halt   = 1'b0;
    iden_1 = 1'b1;
    exen_1 = 1'b1;
    iden_2 = 1'b1;
    exen_2 = 1'b1;
  endtask

  task automatic add(input logic r, input logic e, input logic [2:0] a,
                     input logic s, input logic h, input logic i1,
                     input logic x1, input logic i2, input logic x2,
                     input logic s1, input logic s2, input logic b1,
                     input logic b2, input logic bz, input logic [2:0] rm);
    vec_t v;
    v.rst = r; v.en = e; v.amt = a; v.src = s; v.hlt = h;
    v.id1 = i1; v.ex1 = x1; v.id2 = i2; v.ex2 = x2;
    v.s1 = s1; v.s2 = s2; v.b1 = b1; v.b2 = b2;
    v.busy = bz; v.rem = rm;
    tbl.push_back(v);
  endtask

  initial begin
    int n;
    logic [STAT_W-1:0] exp_sc;
    logic [STAT_W-1:0] exp_bc;
    total = 0;
    bad   = 0;
    idle_in();
    rst = 1'b1;

    //   rst en amt src hlt id1 ex1 id2 ex2 | s1 s2 b1 b2 busy rem
    add(1, 0, 0, 0, 0, 1, 1, 1, 1,  0, 0, 0, 0, 0, 0);
    add(0, 1, 2, 0, 0, 1, 1, 1, 1,  1, 0, 0, 0, 1, 2);
    add(0, 0, 0, 0, 0, 1, 1, 1, 1,  1, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 1, 1, 1, 1,  0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 1, 1, 1, 1,  0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 1, 1,  0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1, 1,  0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1, 1,  0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 1, 1,  0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 1,  0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0);
    add(0, 1, 3, 1, 0, 1, 1, 1, 1,  0, 1, 0, 0, 1, 3);
    add(0, 1, 7, 0, 0, 1, 1, 1, 1,  0, 1, 0, 0, 1, 2);
    add(0, 1, 7, 0, 0, 1, 1, 1, 1,  0, 1, 0, 0, 1, 1);
    add(0, 1, 7, 0, 0, 1, 1, 1, 1,  0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 1, 1,  0, 0, 0, 0, 0, 0);
    add(0, 1, 3, 0, 0, 1, 1, 1, 1,  1, 0, 0, 0, 1, 3);
    add(0, 0, 0, 0, 0, 0, 1, 0, 1,  1, 0, 0, 1, 1, 2);
    add(0, 0, 0, 0, 0, 0, 1, 1, 1,  1, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 1, 1, 1, 1,  0, 0, 0, 0, 0, 0);
    add(0, 1, 2, 1, 1, 1, 1, 1, 1,  0, 1, 0, 0, 1, 2);
    add(0, 0, 0, 0, 1, 1, 1, 1, 1,  0, 1, 0, 0, 1, 2);
    add(0, 0, 0, 0, 0, 1, 1, 1, 1,  0, 1, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 1, 1, 1, 1,  0, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      rst = tbl[i].rst; cd_en = tbl[i].en; cd_amt = tbl[i].amt;
      cd_src = tbl[i].src; halt = tbl[i].hlt;
      iden_1 = tbl[i].id1; exen_1 = tbl[i].ex1;
      iden_2 = tbl[i].id2; exen_2 = tbl[i].ex2;
      step();
      if ({stall_1, stall_2, bubble_ex_1, bubble_ex_2, cd_busy,
           cd_remaining} !== {tbl[i].s1, tbl[i].s2, tbl[i].b1, tbl[i].b2,
                              tbl[i].busy, tbl[i].rem}) begin
        bad++;
        $display("FAIL row%0d: got s1=%b s2=%b b1=%b b2=%b busy=%b rem=%0d want s1=%b s2=%b b1=%b b2=%b busy=%b rem=%0d",
                 i, stall_1, stall_2, bubble_ex_1, bubble_ex_2, cd_busy,
                 cd_remaining, tbl[i].s1, tbl[i].s2, tbl[i].b1, tbl[i].b2,
                 tbl[i].busy, tbl[i].rem);
      end
      total++;
    end

    // halt mid-count: 3 cycles + 4 held cycles on pipe 2
    idle_in();
    cd_en = 1'b1; cd_amt = 3'd3; cd_src = 1'b1;
    step();
    idle_in();
    chk("halt_load_rem", 64'(cd_remaining), 64'd3);
    step();
    chk("halt_pre_rem", 64'(cd_remaining), 64'd2);
    n = 2;
    halt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("halt_hold", 64'({stall_2, stall_1, cd_remaining}), 64'b10_010);
      n++;
    end
    halt = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (!stall_2) break;
      if (stall_1) chk("halt_s1", 64'(stall_1), 64'd0);
      n++;
    end
    chk("halt_len", 64'(n), 64'd7);
    chk("halt_end_busy", 64'(cd_busy), 64'd0);

    // reset in the middle of a count
    cd_en = 1'b1; cd_amt = 3'd3; cd_src = 1'b0;
    step();
    idle_in();
    step();
    chk("rst_pre_rem", 64'(cd_remaining), 64'd2);
    rst = 1'b1;
    iden_1 = 1'b0; exen_1 = 1'b1;
    step();
    chk("rst_outs", 64'({stall_1, stall_2, bubble_ex_1, bubble_ex_2,
                         cd_busy, cd_remaining}), 64'd0);
    chk("rst_stats", 64'({stall_cycles, bubble_count}), 64'd0);
    idle_in();
    step();
    chk("rst_idle", 64'({cd_busy, cd_remaining}), 64'd0);

    // statistics: 4 stall cycles then 2 dual-bubble cycles
    rst = 1'b1;
    step();
    idle_in();
    cd_en = 1'b1; cd_amt = 3'd4; cd_src = 1'b0;
    step();
    idle_in();
    for (int k = 0; k < 4; k++) step();
    chk("stat_idle", 64'(cd_busy), 64'd0);
    iden_1 = 1'b0; exen_1 = 1'b1; iden_2 = 1'b0; exen_2 = 1'b1;
    step();
    step();
    idle_in();
    step();
    step();
`ifdef STALL_STATS_EN
    exp_sc = 32'd4;
    exp_bc = 32'd4;
`else
    exp_sc = 32'd0;
    exp_bc = 32'd0;
`endif
    chk("stall_cycles", 64'(stall_cycles), 64'(exp_sc));
    chk("bubble_count", 64'(bubble_count), 64'(exp_bc));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
